// File: rtl/gate_truth_table_sweeper.sv
// Sweeps every input combination of a small combinational gate, captures its
// truth table after a settle interval and scores it against an expected pattern.
module gate_truth_table_sweeper #(
  parameter int N_IN = 2,
  parameter int SETTLE = 1,
  parameter logic [(2**N_IN)-1:0] EXPECT = 4'b1011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              gate_out,
  output logic [N_IN-1:0]   vec,
  output logic              busy,
  output logic              done,
  output logic [(2**N_IN)-1:0] table_q,
  output logic              match,
  output logic [N_IN:0]     err_count
);

  localparam int W = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [W-1:0] EXP_C = EXPECT;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(W - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [N_IN-1:0] idx_r;
  logic [CW-1:0]   cnt_r;
  logic [N_IN-1:0] vec_r;
  logic            busy_r;
  logic            done_r;
  logic [W-1:0]    table_r;
  logic [W-1:0]    table_nxt_s;
  logic            match_r;
  logic [N_IN:0]   err_r;

  assign vec       = vec_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign table_q   = table_r;
  assign match     = match_r;
  assign err_count = err_r;

  // Next-state decode for the sweep sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_SETTLE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_r == LAST_CNT) state_nxt_s = ST_SAMPLE;
        else                   state_nxt_s = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (idx_r == LAST_IDX) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_SETTLE;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Table including the bit being sampled this cycle, so match is ready with done
  always_comb begin
    table_nxt_s = table_r;
    if (state_r == ST_SAMPLE) table_nxt_s[idx_r] = gate_out;
    else                      table_nxt_s = table_r;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Datapath: vector sequencing, capture, scoring and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r   <= '0;
      cnt_r   <= '0;
      vec_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      table_r <= '0;
      match_r <= 1'b0;
      err_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            idx_r   <= '0;
            vec_r   <= '0;
            cnt_r   <= '0;
            err_r   <= '0;
            table_r <= '0;
            busy_r  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt_r <= cnt_r + CW'(1);
        end
        ST_SAMPLE: begin
          table_r <= table_nxt_s;
          if (gate_out != EXP_C[idx_r]) err_r <= err_r + (N_IN + 1)'(1);
          if (idx_r == LAST_IDX) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            match_r <= (table_nxt_s == EXP_C);
          end else begin
            idx_r <= idx_r + N_IN'(1);
            vec_r <= idx_r + N_IN'(1);
            cnt_r <= '0;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          vec_r  <= '0;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_sweeper.sv
// Randomized self-checking bench: a table-driven gate model feeds two sweepers
// (SETTLE=1 and SETTLE=3) and results are scored against a behavioural model.
module tb_gate_truth_table_sweeper;

  localparam int W = 4;
  localparam logic [3:0] EXP = 4'b1011;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic [3:0] tbl0, tbl1;
  logic       gate_out0, gate_out1;
  logic [1:0] vec0, vec1;
  logic       busy0, busy1, done0, done1, match0, match1;
  logic [3:0] table0, table1;
  logic [2:0] err0, err1;

  logic       sel;
  logic [1:0] obs_vec;
  logic       obs_busy, obs_done, obs_match;
  logic [3:0] obs_table;
  logic [2:0] obs_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign gate_out0 = tbl0[vec0];
  assign gate_out1 = tbl1[vec1];

  gate_truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1011)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .gate_out(gate_out0),
    .vec(vec0), .busy(busy0), .done(done0), .table_q(table0),
    .match(match0), .err_count(err0)
  );

  gate_truth_table_sweeper #(.N_IN(2), .SETTLE(3), .EXPECT(4'b1011)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .gate_out(gate_out1),
    .vec(vec1), .busy(busy1), .done(done1), .table_q(table1),
    .match(match1), .err_count(err1)
  );

  always_comb begin
    if (sel) begin
      obs_vec = vec1; obs_busy = busy1; obs_done = done1;
      obs_table = table1; obs_match = match1; obs_err = err1;
    end else begin
      obs_vec = vec0; obs_busy = busy0; obs_done = done0;
      obs_table = table0; obs_match = match0; obs_err = err0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Number of table entries that disagree with the expected pattern
  function automatic int ref_err(input logic [3:0] tbl);
    logic [3:0] e;
    int n;
    e = EXP;
    n = 0;
    for (int i = 0; i < W; i++) if (tbl[i] != e[i]) n++;
    return n;
  endfunction

  // Truth table of a gate described by its function of a=vec[1], b=vec[0]
  function automatic logic [3:0] gate_tbl(input int kind);
    logic [3:0] t;
    logic a, b;
    for (int i = 0; i < W; i++) begin
      a = (i / 2) % 2 == 1;
      b = i % 2 == 1;
      if (kind == 0) t[i] = ~a | b;
      else           t[i] = ~(a & b);
    end
    return t;
  endfunction

  task automatic sweep(input logic [3:0] tbl, input int s, input bit repulse);
    int total;
    total = W * (s + 1);
    if (s == 1) begin sel = 1'b0; tbl0 = tbl; end
    else        begin sel = 1'b1; tbl1 = tbl; end
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    for (int c = 1; c <= total; c++) begin
      check_val("vec", 32'(obs_vec), 32'((c - 1) / (s + 1)));
      check_val("busy", 32'(obs_busy), 32'd1);
      check_val("done_early", 32'(obs_done), 32'd0);
      set_start(repulse && (c == 2 || c == 5));
      @(negedge clk);
    end
    check_val("done", 32'(obs_done), 32'd1);
    check_val("busy_done", 32'(obs_busy), 32'd0);
    check_val("table_q", 32'(obs_table), 32'(tbl));
    check_val("match", 32'(obs_match), 32'(tbl == EXP));
    check_val("err_count", 32'(obs_err), 32'(ref_err(tbl)));
    set_start(repulse);
    @(negedge clk);
    set_start(1'b0);
    check_val("done_pulse", 32'(obs_done), 32'd0);
    check_val("idle_busy", 32'(obs_busy), 32'd0);
    check_val("table_hold", 32'(obs_table), 32'(tbl));
  endtask

  initial begin
    int exp_done[$];
    int got_done[$];
    int e;
    logic [3:0] rt;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
    tbl0 = 4'b0000; tbl1 = 4'b0000;
    repeat (2) @(negedge clk);
    check_val("rst_vec", 32'({vec0, vec1}), 32'd0);
    check_val("rst_busy", 32'({busy0, busy1}), 32'd0);
    check_val("rst_done", 32'({done0, done1}), 32'd0);
    check_val("rst_table", 32'({table0, table1}), 32'd0);
    check_val("rst_match", 32'({match0, match1}), 32'd0);
    check_val("rst_err", 32'({err0, err1}), 32'd0);
    reset = 1'b0;

    sweep(gate_tbl(0), 1, 1'b0);
    sweep(gate_tbl(1), 1, 1'b0);
    sweep(gate_tbl(0), 1, 1'b1);
    sweep(gate_tbl(1), 1, 1'b1);

    // Reset in the middle of a sweep with a partially mismatching table
    sel = 1'b0;
    tbl0 = 4'b1010;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_err", 32'(err0), 32'd1);
    check_val("pre_rst_vec", 32'(vec0), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_busy", 32'(busy0), 32'd0);
    check_val("mid_rst_vec", 32'(vec0), 32'd0);
    check_val("mid_rst_table", 32'(table0), 32'd0);
    check_val("mid_rst_err", 32'(err0), 32'd0);
    check_val("mid_rst_done", 32'(done0), 32'd0);
    repeat (3) @(negedge clk);
    check_val("post_rst_idle", 32'(busy0), 32'd0);
    sweep(gate_tbl(0), 1, 1'b0);

    sweep(gate_tbl(0), 3, 1'b0);
    sweep(gate_tbl(1), 3, 1'b1);

    for (int k = 0; k < 12; k++) begin
      rt = 4'($urandom_range(0, 15));
      sweep(rt, 1, 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 4; k++) begin
      rt = 4'($urandom_range(0, 15));
      sweep(rt, 3, 1'($urandom_range(0, 1)));
    end

    // Start held high: back-to-back sweeps, one idle cycle apart
    sel = 1'b0;
    tbl0 = gate_tbl(0);
    @(negedge clk);
    start0 = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done0) begin
        got_done.push_back(c);
        check_val("held_match", 32'(match0), 32'd1);
        check_val("held_table", 32'(table0), 32'(gate_tbl(0)));
      end
      if (c == 30) start0 = 1'b0;
    end
    e = 1;
    while (e <= 30) begin
      exp_done.push_back(e + W * 2);
      e += W * 2 + 2;
    end
    check_val("held_count", 32'(got_done.size()), 32'(exp_done.size()));
    for (int i = 0; i < exp_done.size(); i++) begin
      if (i < got_done.size()) check_val("held_time", 32'(got_done[i]), 32'(exp_done[i]));
      else                     check_val("held_time", 32'hffff_ffff, 32'(exp_done[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
